// File: rtl/seg_capture_pkg.sv
// -----------------------------------------------------------------------------
// seg_capture_pkg
// Shared definitions for the 7-segment capture monitor:
//   - active-low segment patterns for the digits 0-9 and for a blank position,
//     bit order {g,f,e,d,c,b,a}
//   - digit codes used for blank and unrecognised positions
//   - the capture FSM state type and the anode classification type
//   - helpers that classify an active-low anode vector and locate its low bit
// -----------------------------------------------------------------------------
package seg_capture_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] DIG_BLANK = 4'hF;
    localparam logic [3:0] DIG_BAD   = 4'hE;

    localparam logic [3:0] AN_NONE   = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        HELD  = 2'd2
    } cap_state_e;

    typedef enum logic [1:0] {
        AN_OFF   = 2'd0,
        AN_ONE   = 2'd1,
        AN_MULTI = 2'd2
    } an_class_e;

    // The anodes are active low: invert, then a power-of-two test tells
    // "exactly one selected" apart from "several selected".
    function automatic an_class_e classify_an(input logic [3:0] an);
        logic [3:0] act;
        act = ~an;
        if (act == 4'b0000) begin
            return AN_OFF;
        end else if ((act & (act - 4'd1)) == 4'b0000) begin
            return AN_ONE;
        end else begin
            return AN_MULTI;
        end
    endfunction

    // Index of the low anode bit; only meaningful when classify_an() == AN_ONE.
    function automatic logic [1:0] anode_index(input logic [3:0] an);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!an[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg_capture_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational decoder from an active-low 7-segment pattern to a digit code.
//   seg_i      [6:0]  active-low segments {g,f,e,d,c,b,a}
//   code_o     [3:0]  0-9 for a digit, DIG_BLANK for all-off, DIG_BAD otherwise
//   is_blank_o        pattern was all segments off
//   is_bad_o          pattern is neither a digit nor blank
// -----------------------------------------------------------------------------
module seg7_decode
    import seg_capture_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] code_o,
    output logic       is_blank_o,
    output logic       is_bad_o
);

    always_comb begin
        code_o     = DIG_BAD;
        is_blank_o = 1'b0;
        is_bad_o   = 1'b0;
        case (seg_i)
            SEG_0:     code_o = 4'd0;
            SEG_1:     code_o = 4'd1;
            SEG_2:     code_o = 4'd2;
            SEG_3:     code_o = 4'd3;
            SEG_4:     code_o = 4'd4;
            SEG_5:     code_o = 4'd5;
            SEG_6:     code_o = 4'd6;
            SEG_7:     code_o = 4'd7;
            SEG_8:     code_o = 4'd8;
            SEG_9:     code_o = 4'd9;
            SEG_BLANK: begin
                code_o     = DIG_BLANK;
                is_blank_o = 1'b1;
            end
            default:   is_bad_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_capture.sv
// -----------------------------------------------------------------------------
// seg_capture
// Receive side of a multiplexed 4-digit 7-segment display. Samples the seg/an
// lines driven by the display scanner, waits for each digit to be stable for
// STABLE_CYCLES samples, collects all four positions and publishes them as one
// frame. Used as a self-check monitor of what the display actually shows.
//
// Parameters
//   STABLE_CYCLES   identical (an, seg) samples needed to accept a digit (2..255)
//   TIMEOUT_CYCLES  cycles without a published frame before stale asserts
//
// Ports
//   clk_i           system clock
//   rst_i           synchronous, active-high reset
//   seg_i   [7:0]   active-low segments, [6:0] = {g,f,e,d,c,b,a}, [7] = dp
//   an_i    [3:0]   active-low anodes: [3] min_ten, [2] min_one, [1] sec_ten,
//                   [0] sec_one
//   min_ten_o, min_one_o, sec_ten_o, sec_one_o [3:0]  published digit codes
//   blank_o [3:0]   published blank flags, same order as an_i
//   dp_o    [3:0]   published decimal points, same order as an_i
//   frame_valid_o   one-cycle pulse when a new frame is published
//   err_anode_o     sticky: more than one anode was low at once
//   err_seg_o       sticky: an unrecognised pattern was latched
//   stale_o         no frame published within TIMEOUT_CYCLES
//
// Build option
//   SEG_CAPTURE_DP_EN  when defined, seg_i[7] joins the stability compare and
//                      is captured into dp_o; otherwise it is ignored and dp_o
//                      stays 4'b0000.
//
// Capture FSM
//   state | meaning
//   IDLE  | no digit active (all anodes high, or an illegal anode sample)
//   DWELL | one anode active, counting identical samples
//   HELD  | digit latched, waiting for the sample to change
// -----------------------------------------------------------------------------
module seg_capture
    import seg_capture_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] seg_i,
    input  logic [3:0] an_i,
    output logic [3:0] min_ten_o,
    output logic [3:0] min_one_o,
    output logic [3:0] sec_ten_o,
    output logic [3:0] sec_one_o,
    output logic [3:0] blank_o,
    output logic [3:0] dp_o,
    output logic       frame_valid_o,
    output logic       err_anode_o,
    output logic       err_seg_o,
    output logic       stale_o
);

    // STABLE_CYCLES is limited to 255, so an 8-bit dwell counter suffices.
    localparam int unsigned CNT_W = 8;
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] STABLE_TC = CNT_W'(STABLE_CYCLES);
    localparam logic [TMO_W-1:0] TMO_TC    = TMO_W'(TIMEOUT_CYCLES);

`ifdef SEG_CAPTURE_DP_EN
    localparam int unsigned KEY_W = 12;
`else
    localparam int unsigned KEY_W = 11;
`endif

    // input registers and the previous-sample copy used for stability checks
    logic [3:0]       an_q;
    logic [7:0]       seg_q;
    logic [KEY_W-1:0] key_cur;
    logic [KEY_W-1:0] key_prev_q;

    // capture FSM
    cap_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // shadow slots filled one position at a time
    logic [3:0]       mask_q, mask_d;
    logic [3:0]       shadow_code_q [4];
    logic [3:0]       shadow_blank_q;
    logic [3:0]       shadow_dp_q;

    // published frame
    logic [3:0]       digit_q [4];
    logic [3:0]       blank_q;
    logic [3:0]       dp_q;
    logic             frame_valid_q;

    logic             err_anode_q;
    logic             err_seg_q;
    logic [TMO_W-1:0] tmo_q;

    an_class_e        an_class;
    logic [1:0]       pos;
    logic             same_sample;
    logic             latch;
    logic             publish;
    logic             cap_dp;

    logic [3:0]       dec_code;
    logic             dec_blank;
    logic             dec_bad;

    // -------------------------------------------------------------------------
    // Sample classification
    // -------------------------------------------------------------------------
`ifdef SEG_CAPTURE_DP_EN
    assign key_cur = {an_q, seg_q};
    assign cap_dp  = ~seg_q[7];
`else
    logic seg_dp_unused;
    assign seg_dp_unused = seg_q[7];
    assign key_cur       = {an_q, seg_q[6:0]};
    assign cap_dp        = 1'b0;
`endif

    assign an_class    = classify_an(an_q);
    assign pos         = anode_index(an_q);
    assign same_sample = (key_cur == key_prev_q);

    seg7_decode u_decode (
        .seg_i      (seg_q[6:0]),
        .code_o     (dec_code),
        .is_blank_o (dec_blank),
        .is_bad_o   (dec_bad)
    );

    // -------------------------------------------------------------------------
    // Capture FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (an_class == AN_ONE) begin
                    state_d = DWELL;
                    cnt_d   = CNT_W'(1);
                end
            end
            DWELL: begin
                if (same_sample) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == STABLE_TC) begin
                        latch   = 1'b1;
                        state_d = HELD;
                    end
                end else if (an_class == AN_ONE) begin
                    cnt_d = CNT_W'(1);
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            HELD: begin
                // A held digit never re-latches; only a change can restart it.
                if (!same_sample) begin
                    if (an_class == AN_ONE) begin
                        state_d = DWELL;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Slot mask and frame publish
    // -------------------------------------------------------------------------
    // A full mask is published one cycle after it fills. Clearing it on the
    // publish cycle still keeps any slot latched in that same cycle.
    assign publish = (mask_q == 4'b1111);

    always_comb begin
        mask_d = publish ? 4'b0000 : mask_q;
        if (latch) begin
            mask_d[pos] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            an_q       <= AN_NONE;
            seg_q      <= 8'hFF;
            key_prev_q <= '1;
            mask_q     <= 4'b0000;
        end else begin
            an_q       <= an_i;
            seg_q      <= seg_i;
            key_prev_q <= key_cur;
            mask_q     <= mask_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 4; i++) begin
                shadow_code_q[i] <= DIG_BLANK;
            end
            shadow_blank_q <= 4'b1111;
            shadow_dp_q    <= 4'b0000;
        end else if (latch) begin
            shadow_code_q[pos]  <= dec_code;
            shadow_blank_q[pos] <= dec_blank;
            shadow_dp_q[pos]    <= cap_dp;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 4; i++) begin
                digit_q[i] <= DIG_BLANK;
            end
            blank_q       <= 4'b1111;
            dp_q          <= 4'b0000;
            frame_valid_q <= 1'b0;
        end else begin
            frame_valid_q <= publish;
            if (publish) begin
                digit_q <= shadow_code_q;
                blank_q <= shadow_blank_q;
                dp_q    <= shadow_dp_q;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sticky errors and frame timeout
    // -------------------------------------------------------------------------
    // err_seg is raised when a bad pattern is actually latched, so segment
    // transitions between digits do not trip it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_anode_q <= 1'b0;
            err_seg_q   <= 1'b0;
        end else begin
            if (an_class == AN_MULTI) begin
                err_anode_q <= 1'b1;
            end
            if (latch && dec_bad) begin
                err_seg_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_q <= '0;
        end else if (publish) begin
            tmo_q <= '0;
        end else if (tmo_q != TMO_TC) begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign sec_one_o     = digit_q[0];
    assign sec_ten_o     = digit_q[1];
    assign min_one_o     = digit_q[2];
    assign min_ten_o     = digit_q[3];
    assign blank_o       = blank_q;
    assign dp_o          = dp_q;
    assign frame_valid_o = frame_valid_q;
    assign err_anode_o   = err_anode_q;
    assign err_seg_o     = err_seg_q;
    assign stale_o       = (tmo_q == TMO_TC);

endmodule

// File: doc/seg_capture.md
Name: seg_capture

Overview:
- Receive end of the multiplexed 7-segment display interface: samples the seg/an lines driven by the display scanner and rebuilds the four displayed digits as BCD.
- Used as an on-board/self-check monitor so counter values can be compared against what is actually shown.
- Single clock domain (clk); all inputs are registered once before use.

Parameters:
- STABLE_CYCLES, 4, consecutive identical (an, seg) samples required before a digit is accepted; valid range 2..255.
- TIMEOUT_CYCLES, 1000000, cycles without a completed frame before stale asserts.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- seg  input  8  active-low segments; seg[6:0] = {g,f,e,d,c,b,a}; seg[7] = dp
- an  input  4  active-low anode select; an[3] = min_ten, an[2] = min_one, an[1] = sec_ten, an[0] = sec_one
- min_ten, min_one, sec_ten, sec_one  output  4 each  captured digit codes
- blank  output  4  per-position blank flags, same bit order as an
- dp  output  4  captured decimal points (see Optional Feature)
- frame_valid  output  1  one-cycle pulse when a full four-digit frame is published
- err_anode  output  1  sticky flag: more than one anode was low
- err_seg  output  1  sticky flag: an unrecognised segment pattern was seen
- stale  output  1  high while no frame has completed within TIMEOUT_CYCLES

Behaviour:
- Reset:
  - All digit outputs = 4'hF; blank = 4'b1111; dp = 0.
  - frame_valid, err_anode, err_seg, stale = 0.
  - Capture mask and counters cleared; FSM goes to IDLE.
- Anode classification on registered an:
  - 4'b1111: no digit active.
  - Exactly one bit low: valid position.
  - Two or more bits low: set err_anode, treat the sample as no digit active.
- Segment decode:
  - Patterns 0x40, 0x79, 0x24, 0x30, 0x19, 0x12, 0x02, 0x78, 0x00, 0x10 decode to 0-9.
  - 0x7F decodes to 4'hF with the blank bit set.
  - Any other pattern decodes to 4'hE and sets err_seg.
- FSM:
  - IDLE: valid position seen -> DWELL, stability count = 1.
  - DWELL: each cycle, if (an, seg) equals the previous sample, increment the count; otherwise restart it at 1 (or go to IDLE if no digit is active).
  - When the count reaches STABLE_CYCLES: write the decoded code, blank and dp into the shadow slot for that position, set its mask bit, go to HELD.
  - HELD: stays until (an, seg) changes, so each dwell latches at most once. On change -> DWELL (valid position) or IDLE (no digit).
- Frame publish:
  - Rewriting a position whose mask bit is already set overwrites that shadow slot.
  - On the cycle after the mask becomes 4'b1111: copy all shadow slots to the outputs together, pulse frame_valid for one cycle, clear the mask.
- Latency: 1 input-register cycle + STABLE_CYCLES to latch a slot; +1 cycle to publish.
- Timeout counter:
  - Saturating; cleared on each frame_valid.
  - stale = 1 when the count reaches TIMEOUT_CYCLES; clears on the next frame_valid.
  - Outputs keep their last published values while stale.
- Sticky errors clear only on rst.
- rst mid-dwell discards the partial mask and shadow contents.

Optional Feature:
- Macro: SEG_CAPTURE_DP_EN.
- Defined: seg[7] is included in the stability compare; dp[i] = ~seg[7] for the captured sample, published with the frame.
- Undefined: seg[7] is ignored everywhere; dp is driven 4'b0000.

Decomposition:
- Package seg_capture_pkg:
  - Ten segment-pattern constants plus SEG_BLANK = 7'h7F.
  - Digit code constants DIG_BLANK = 4'hF and DIG_BAD = 4'hE.
  - FSM state enum {IDLE, DWELL, HELD}.
- Sub-module seg7_decode: combinational; seg[6:0] -> code[3:0], is_blank, is_bad. Instantiated once.
- Frame FSM and counters stay in the top.

Test Plan:
- Scan an = 1110/1101/1011/0111 with seg = 0x24/0x19/0x79/0x30, dwell 10 cycles each -> frame_valid pulses once; min_ten = 3, min_one = 1, sec_ten = 4, sec_one = 2; blank = 0.
- Dwell 3 cycles per digit with STABLE_CYCLES = 4 -> no latch, no frame_valid, stale after TIMEOUT_CYCLES (use 1000 in the bench).
- Scan with seg = 0x7F on an[3] -> min_ten = 4'hF, blank = 4'b1000; the other digits decode normally.
- Drive an = 4'b1100 for one cycle mid-frame -> err_anode = 1 and stays 1; the frame still completes from valid samples.
- Drive seg = 0x55 on a valid dwell -> err_seg = 1 and that digit = 4'hE. Assert rst mid-dwell -> all outputs return to reset values the next cycle.
- With SEG_CAPTURE_DP_EN, seg[7] = 0 on an[2] -> dp = 4'b0100. Without the macro -> dp = 0.
